// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED phase sequencer.
//   state_e     - sequencer state, 2 bits (IDLE=0, RED=1, BLUE=2, GREEN=3)
//   LED_*       - active-low RGB drive patterns for each colour
//   led_decode  - state to LED pattern (IDLE shows RED)
//   next_colour - colour order RED -> BLUE -> GREEN -> RED
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RED   = 2'd1,
    ST_BLUE  = 2'd2,
    ST_GREEN = 2'd3
  } state_e;

  localparam logic [2:0] LED_RED   = 3'b110;
  localparam logic [2:0] LED_BLUE  = 3'b011;
  localparam logic [2:0] LED_GREEN = 3'b101;

  function automatic logic [2:0] led_decode(input state_e s);
    logic [2:0] l;
    l = LED_RED;
    case (s)
      ST_BLUE:  l = LED_BLUE;
      ST_GREEN: l = LED_GREEN;
      default:  l = LED_RED;
    endcase
    return l;
  endfunction

  function automatic state_e next_colour(input state_e s);
    state_e n;
    n = ST_RED;
    case (s)
      ST_RED:  n = ST_BLUE;
      ST_BLUE: n = ST_GREEN;
      default: n = ST_RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces one raw active-low button and
// turns each accepted press into a single-cycle event.
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   btn_n  - raw button, active-low, asynchronous to clk
//   press  - one-cycle pulse in the first cycle the debounced level reads 0
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 270_000,
  parameter int CNT_W          = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = btn_n;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    // The counter measures how long the synchronised level has disagreed
    // with the accepted level; any agreement restarts the measurement.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
    end
  end

  // Falling edge of the accepted level only; release produces nothing.
  assign press = stable_dly_q & ~stable_q;

endmodule

// File: rtl/led_phase_sequencer.sv
// led_phase_sequencer: steps the RGB LED through RED -> BLUE -> GREEN phases
// of PHASE_TICKS cycles each, controlled by debounced start/stop buttons.
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   btn_start_n - raw start button (active-low, asynchronous)
//   btn_stop_n  - raw stop button (active-low, asynchronous)
//   hold        - synchronous freeze of phase counter and state
//   led         - active-low colour drive
//   phase       - current state encoding (IDLE=0, RED=1, BLUE=2, GREEN=3)
//   busy        - high in any state other than IDLE
//   cycle_done  - one-cycle pulse on the GREEN -> RED wrap
module led_phase_sequencer
  import led_pkg::*;
#(
  parameter int PHASE_TICKS    = 30_000_000,
  parameter int DEBOUNCE_TICKS = 270_000,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_n,
  input  logic       btn_stop_n,
  input  logic       hold,
  output logic [2:0] led,
  output logic [1:0] phase,
  output logic       busy,
  output logic       cycle_done
);

  localparam logic [CNT_W-1:0] PHASE_MAX = CNT_W'(PHASE_TICKS - 1);

  logic start_press;
  logic stop_press;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cycle_done_q, cycle_done_d;

  btn_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .CNT_W          (CNT_W)
  ) u_start_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_start_n),
    .press (start_press)
  );

  btn_debounce #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .CNT_W          (CNT_W)
  ) u_stop_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_stop_n),
    .press (stop_press)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cycle_done_d = 1'b0;
    // Button events override hold so the sequence can always be stopped or
    // restarted; a start entry to RED is not a completed cycle.
    if (stop_press) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start_press) begin
      state_d = ST_RED;
      cnt_d   = '0;
    end else if (!hold && state_q != ST_IDLE) begin
      if (cnt_q == PHASE_MAX) begin
        state_d      = next_colour(state_q);
        cnt_d        = '0;
        cycle_done_d = (state_q == ST_GREEN);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign led        = led_decode(state_q);
  assign phase      = state_q;
  assign busy       = (state_q != ST_IDLE);
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_phase_sequencer.sv
module tb_led_phase_sequencer;

  localparam int P = 5;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bs = 1'b1;
  logic       bp = 1'b1;
  logic       hold = 1'b0;
  logic [2:0] led;
  logic [1:0] phase;
  logic       busy;
  logic       cycle_done;

  led_phase_sequencer #(
    .PHASE_TICKS    (P),
    .DEBOUNCE_TICKS (D),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_start_n (bs),
    .btn_stop_n  (bp),
    .hold        (hold),
    .led         (led),
    .phase       (phase),
    .busy        (busy),
    .cycle_done  (cycle_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference: index 0 = start button, 1 = stop button.
  int m_s1[2], m_s2[2], m_stab[2], m_run[2], m_press[2];
  int m_ph;    // 0 idle, 1 red, 2 blue, 3 green
  int m_left;  // cycles remaining in the current colour
  int m_cd;

  int cd_cnt = 0;
  int cur_ph = 0;
  int cur_len = 0;
  int last_len[4];

  function automatic logic [2:0] led_of(input int ph);
    case (ph)
      2:       return 3'b011;
      3:       return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1; m_s2[i] = 1; m_stab[i] = 1; m_run[i] = 0; m_press[i] = 0;
    end
    m_ph = 0; m_left = P; m_cd = 0;
  endtask

  task automatic m_edge();
    int raw[2];
    int prev;
    // Sequencer reacts to events that were visible before this edge.
    m_cd = 0;
    if (m_press[1] != 0) begin
      m_ph = 0; m_left = P;
    end else if (m_press[0] != 0) begin
      m_ph = 1; m_left = P;
    end else if (!hold && m_ph != 0) begin
      if (m_left == 1) begin
        m_cd   = (m_ph == 3) ? 1 : 0;
        m_ph   = (m_ph == 3) ? 1 : m_ph + 1;
        m_left = P;
      end else begin
        m_left--;
      end
    end
    raw[0] = int'(bs);
    raw[1] = int'(bp);
    for (int i = 0; i < 2; i++) begin
      prev = m_stab[i];
      // A new level is accepted after D consecutive disagreeing samples.
      if (m_s2[i] != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_stab[i] = m_s2[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_press[i] = (prev == 1 && m_stab[i] == 0) ? 1 : 0;
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("led",        32'(led),        32'(led_of(m_ph)));
    chk("phase",      32'(phase),      32'(m_ph));
    chk("busy",       32'(busy),       (m_ph != 0) ? 32'd1 : 32'd0);
    chk("cycle_done", 32'(cycle_done), 32'(m_cd));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_edge();
    #1;
    check_all();
    if (cycle_done === 1'b1) cd_cnt++;
    if (int'(phase) == cur_ph) begin
      cur_len++;
    end else begin
      last_len[cur_ph] = cur_len;
      cur_ph  = int'(phase);
      cur_len = 1;
    end
  endtask

  // Waits for a fresh entry into colour ph, bounded in cycles.
  task automatic wait_enter(input int ph, input string tag);
    for (int i = 0; i < 30 && int'(phase) == ph; i++) tick();
    for (int i = 0; i < 30 && int'(phase) != ph; i++) tick();
    chk(tag, 32'(phase), 32'(ph));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) last_len[i] = 0;
    m_reset();

    // Reset then idle
    #1 rst_n = 1'b0;
    #1;
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
    cd_cnt = 0;
    repeat (20) tick();
    chk("idle_cd_never", 32'(cd_cnt), 32'd0);
    chk("idle_led", 32'(led), 32'b110);

    // Bounce rejection: low/high every 2 cycles
    for (int i = 0; i < 5; i++) begin
      bs = 1'b0; tick(); tick();
      bs = 1'b1; tick(); tick();
    end
    repeat (10) tick();
    chk("bounce_phase", 32'(phase), 32'd0);
    chk("bounce_busy", 32'(busy), 32'd0);

    // Start and one full cycle
    cd_cnt = 0;
    bs = 1'b0;
    repeat (10) tick();
    bs = 1'b1;
    repeat (20) tick();
    chk("cycle_cd_once", 32'(cd_cnt), 32'd1);
    chk("red_len", 32'(last_len[1]), 32'd5);
    chk("blue_len", 32'(last_len[2]), 32'd5);
    chk("green_len", 32'(last_len[3]), 32'd5);

    // Hold during BLUE
    wait_enter(2, "wait_blue");
    cd_cnt = 0;
    hold = 1'b1;
    repeat (7) tick();
    hold = 1'b0;
    for (int i = 0; i < 20 && phase == 2'd2; i++) tick();
    chk("hold_blue_len", 32'(last_len[2]), 32'd12);
    chk("hold_no_cd", 32'(cd_cnt), 32'd0);

    // Simultaneous press while (held) in GREEN
    wait_enter(3, "wait_green");
    hold = 1'b1; bs = 1'b0; bp = 1'b0;
    repeat (7) tick();
    chk("simul_stop_wins", 32'(phase), 32'd0);
    hold = 1'b0; bs = 1'b1; bp = 1'b1;
    repeat (8) tick();
    chk("simul_idle", 32'(phase), 32'd0);

    // Restart mid-BLUE
    bs = 1'b0;
    repeat (4) tick();
    bs = 1'b1;
    wait_enter(2, "wait_blue2");
    tick();
    hold = 1'b1; bs = 1'b0;
    repeat (7) tick();
    chk("restart_phase", 32'(phase), 32'd1);
    chk("restart_cd_low", 32'(cycle_done), 32'd0);
    hold = 1'b0; bs = 1'b1;
    repeat (5) tick();
    chk("restart_red_len", 32'(last_len[1]), 32'd5);
    chk("restart_blue", 32'(phase), 32'd2);

    // Asynchronous reset mid-GREEN
    wait_enter(3, "wait_green2");
    tick();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("rst_led", 32'(led), 32'b110);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    cd_cnt = 0;
    repeat (10) tick();
    chk("post_rst_idle", 32'(phase), 32'd0);
    chk("post_rst_cd", 32'(cd_cnt), 32'd0);

    // Randomised buttons and hold against the reference
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) bs = ~bs;
      if ($urandom_range(0, 11) == 0) bp = ~bp;
      hold = ($urandom_range(0, 5) == 0);
      tick();
    end
    bs = 1'b1; bp = 1'b1; hold = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_phase_sequencer.md
# led_phase_sequencer

Sequences the on-board RGB LED through RED → BLUE → GREEN phases of fixed, parameterised length, driven by two raw active-low push buttons. Each button is synchronised and debounced internally. Presses become single-cycle events, with stop taking priority over start. The block sits between the board buttons and the LED pins and replaces ad-hoc button sampling with a clean, restartable, pausable scheduler.

## Interface
- `PHASE_TICKS`, 30_000_000: clk cycles per colour phase; legal range ≥2.
- `DEBOUNCE_TICKS`, 270_000: cycles a synchronised button level must hold before it is accepted; legal range ≥1.
- `CNT_W`, 32: width of the phase and debounce counters; must hold `PHASE_TICKS-1` and `DEBOUNCE_TICKS-1`.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `btn_start_n`  in  1  raw start button, active-low, asynchronous to `clk`.
- `btn_stop_n`  in  1  raw stop button, active-low, asynchronous to `clk`.
- `hold`  in  1  synchronous level; freezes the phase counter and state while high.
- `led`  out  3  active-low colour; RED=3'b110, BLUE=3'b011, GREEN=3'b101.
- `phase`  out  2  current state encoding (IDLE=0, RED=1, BLUE=2, GREEN=3).
- `busy`  out  1  high in any state except IDLE.
- `cycle_done`  out  1  one-cycle pulse when GREEN completes and the FSM wraps to RED.

## Operation
- **Reset values:**
  - state IDLE, `led`=3'b110, `phase`=0, `busy`=0, `cycle_done`=0.
  - Phase counter 0.
  - Debouncer stable levels 1 (released), sync flops 1.
- **Debounce, per button:**
  - 2-flop synchroniser produces `s2`.
  - Counter clears when `s2`==stable; otherwise it increments.
  - When the counter is at `DEBOUNCE_TICKS-1` and `s2`≠stable: stable<=`s2` and the counter clears.
  - `press` = stable_d & ~stable, a one-cycle pulse in the first cycle stable reads 0. Release generates no event.
- **FSM:** states IDLE, RED, BLUE, GREEN. Priority per cycle, highest first:
  1. stop press → IDLE, counter 0; applies even if `hold` is high.
  2. start press → RED, counter 0; this restarts the sequence from any state, including mid-phase and while held.
  3. `hold` high → no change.
  4. Counter at `PHASE_TICKS-1` → next state, counter 0. Order is RED→BLUE→GREEN→RED; GREEN→RED also asserts `cycle_done`.
  5. Otherwise, counter+1 when not IDLE.
- IDLE ignores the counter (held at 0) and shows RED.
- `led` and `phase` are pure decodes of the state register. `busy` = (state≠IDLE).
- Simultaneous start and stop press → stop wins.
- Counter never exceeds `PHASE_TICKS-1`; there is no wrap-around beyond the compare.

## Timing
- Raw button low sampled at edge k: `s2` low after edge k+1; stable low and `press` high after edge k+1+`DEBOUNCE_TICKS`. The FSM transitions at edge k+2+`DEBOUNCE_TICKS`.
- A glitch shorter than `DEBOUNCE_TICKS` cycles at `s2` produces no event.
- State change to `led`/`phase`/`busy`: 0 cycles (same edge).
- An un-held phase lasts exactly `PHASE_TICKS` cycles. Each held cycle extends the current phase by one cycle.
- `cycle_done` is high for exactly the first cycle of the new RED after GREEN. It is not asserted on a start-press entry to RED.
- `rst_n` assertion mid-phase: all outputs return to reset values immediately (asynchronously). Release is synchronous to `clk`.

## Structure
- `led_pkg`: state enum (IDLE/RED/BLUE/GREEN, 2 bits) and LED colour constants RED, BLUE, GREEN.
- Sub-module `btn_debounce` (params `DEBOUNCE_TICKS`, `CNT_W`; ports `clk`, `rst_n`, `btn_n`, `press`), instantiated twice.
- Top holds the FSM and the phase counter only.

## Test plan
Bench parameters: `PHASE_TICKS`=5, `DEBOUNCE_TICKS`=4.
- **Reset then idle:** reset, idle 20 cycles → `led`=110, `phase`=0, `busy`=0, `cycle_done` never high.
- **Start and full cycle:** `btn_start_n` low for 10 cycles → `phase` 1 for 5 cycles, then 2 for 5, then 3 for 5, then 1. `led` follows 110/011/101. `cycle_done` pulses once on the 3→1 wrap.
- **Bounce rejection:** `btn_start_n` toggled low/high every 2 cycles for 20 cycles, then held high → `phase` stays 0.
- **Hold:** `hold` high for 7 cycles during BLUE → BLUE lasts 12 cycles, counter frozen, no `cycle_done`.
- **Simultaneous press and restart:** both buttons low at the same edge while in GREEN → IDLE. Then a start press mid-BLUE → RED with counter 0 and `cycle_done` low.
- **Reset mid-operation:** `rst_n` low for 1 cycle mid-GREEN → `led`=110, `phase`=0, `busy`=0 immediately. No event while the button remains released.
